// File: rtl/controller_mc.sv
// Multicycle fetch/execute sequencer for the CDEC datapath: decodes the IR into strobes,
// handles memory ready waits, single-step pausing, halt/resume, wait timeout and retire count.
`timescale 1ns/1ps
module controller_mc #(
  parameter int unsigned IW      = 8,
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned TIMEOUT = 0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [IW-1:0]    I,
  input  logic [2:0]       SZCy,
  input  logic             mem_ready,
  input  logic             step_mode,
  input  logic             step_go,
  input  logic             resume,
  output logic [3:0]       aluop,
  output logic             Rwe,
  output logic             FLGwe,
  output logic             MEMwe,
  output logic             mem_req,
  output logic             ir_we,
  output logic             pc_inc,
  output logic             pc_load,
  output logic             illegal,
  output logic             bus_err,
  output logic             halt,
  output logic [2:0]       dbg_state,
  output logic [CNT_W-1:0] retired
);

  localparam logic [2:0] F0    = 3'd0;
  localparam logic [2:0] F1    = 3'd1;
  localparam logic [2:0] X0    = 3'd2;
  localparam logic [2:0] PAUSE = 3'd3;
  localparam logic [2:0] HLT   = 3'd4;

  localparam logic [3:0] OP_LD  = 4'h8;
  localparam logic [3:0] OP_ST  = 4'h9;
  localparam logic [3:0] OP_JMP = 4'hA;
  localparam logic [3:0] OP_HLT = 4'hF;

  // Wait counter only ever needs to hold TIMEOUT-1.
  localparam int unsigned WCW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [2:0]       state_q, state_d;
  logic [WCW-1:0]   wait_q, wait_d;
  logic             bus_err_q, bus_err_d;
  logic             step_go_q;
  logic [CNT_W-1:0] retired_q, retired_d;

  logic [3:0] opcode;
  logic       is_mem_op;
  logic       waiting;
  logic       timeout_hit;
  logic       step_edge;
  logic       cond_raw;
  logic       jmp_take;
  logic       retire;

  assign opcode    = I[IW-1 -: 4];
  assign is_mem_op = (opcode == OP_LD) || (opcode == OP_ST);
  assign step_edge = step_go & ~step_go_q;

  // IR bits between the condition field and the opcode carry no control meaning.
  logic unused_ir_bits;
  assign unused_ir_bits = ^I[IW-5:3];

  assign waiting = !mem_ready && ((state_q == F1) || ((state_q == X0) && is_mem_op));
  assign timeout_hit = (TIMEOUT != 0) && waiting && (32'(wait_q) == (TIMEOUT - 32'd1));

  always_comb begin
    cond_raw = 1'b1;
    case (I[1:0])
      2'b00:   cond_raw = 1'b1;
      2'b01:   cond_raw = SZCy[2];
      2'b10:   cond_raw = SZCy[1];
      default: cond_raw = SZCy[0];
    endcase
  end

  assign jmp_take = cond_raw ^ I[2];

  always_comb begin
    state_d = state_q;
    retire  = 1'b0;
    case (state_q)
      F0: state_d = F1;
      F1: begin
        if (mem_ready) begin
          state_d = X0;
        end else if (timeout_hit) begin
          state_d = HLT;
        end
      end
      X0: begin
        if (is_mem_op && !mem_ready) begin
          if (timeout_hit) begin
            state_d = HLT;
          end
        end else begin
          retire = 1'b1;
          if (opcode == OP_HLT) begin
            state_d = HLT;
          end else if (step_mode) begin
            state_d = PAUSE;
          end else begin
            state_d = F0;
          end
        end
      end
      PAUSE: begin
        if (step_edge || !step_mode) begin
          state_d = F0;
        end
      end
      HLT: begin
        if (resume) begin
          state_d = F0;
        end
      end
      default: state_d = F0;
    endcase
  end

  // Counts only consecutive stalled cycles within one state.
  always_comb begin
    wait_d = '0;
    if ((TIMEOUT != 0) && waiting && (state_d == state_q)) begin
      wait_d = wait_q + WCW'(1);
    end
  end

  assign bus_err_d = bus_err_q | timeout_hit;
  assign retired_d = retired_q + CNT_W'(retire);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= F0;
      wait_q    <= '0;
      bus_err_q <= 1'b0;
      step_go_q <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      bus_err_q <= bus_err_d;
      step_go_q <= step_go;
      retired_q <= retired_d;
    end
  end

  always_comb begin
    aluop   = 4'h0;
    Rwe     = 1'b0;
    FLGwe   = 1'b0;
    MEMwe   = 1'b0;
    mem_req = 1'b0;
    ir_we   = 1'b0;
    pc_inc  = 1'b0;
    pc_load = 1'b0;
    illegal = 1'b0;
    halt    = 1'b0;
    case (state_q)
      F0: mem_req = 1'b1;
      F1: begin
        mem_req = 1'b1;
        ir_we   = mem_ready;
        pc_inc  = mem_ready;
      end
      X0: begin
        case (opcode)
          4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7: begin
            aluop = opcode;
            Rwe   = 1'b1;
            FLGwe = 1'b1;
          end
          OP_LD: begin
            mem_req = 1'b1;
            Rwe     = mem_ready;
          end
          OP_ST: begin
            mem_req = 1'b1;
            MEMwe   = 1'b1;
          end
          OP_JMP: pc_load = jmp_take;
          4'hB, 4'hC, 4'hD, 4'hE: illegal = 1'b1;
          default: ;
        endcase
      end
      HLT:     halt = 1'b1;
      default: ;
    endcase
  end

  assign bus_err   = bus_err_q;
  assign dbg_state = state_q;
  assign retired   = retired_q;

endmodule

// File: tb/tb_controller_mc.sv
// Cycle-accurate scoreboard bench for controller_mc: each driven cycle pushes its expected
// outputs, and a negedge monitor pops and compares them.
`timescale 1ns/1ps
module tb_controller_mc;

  localparam int unsigned IW      = 8;
  localparam int unsigned CNT_W   = 3;
  localparam int unsigned TIMEOUT = 4;

  localparam logic [2:0] SF0 = 3'd0, SF1 = 3'd1, SX0 = 3'd2, SPAUSE = 3'd3, SHLT = 3'd4;

  localparam logic [9:0] RWE   = 10'h200;
  localparam logic [9:0] FLGWE = 10'h100;
  localparam logic [9:0] MEMWE = 10'h080;
  localparam logic [9:0] MREQ  = 10'h040;
  localparam logic [9:0] IRWE  = 10'h020;
  localparam logic [9:0] PCINC = 10'h010;
  localparam logic [9:0] PCLD  = 10'h008;
  localparam logic [9:0] ILL   = 10'h004;
  localparam logic [9:0] BERR  = 10'h002;
  localparam logic [9:0] HALT  = 10'h001;
  localparam logic [9:0] NONE  = 10'h000;

  logic             clock;
  logic             reset;
  logic [IW-1:0]    I;
  logic [2:0]       SZCy;
  logic             mem_ready, step_mode, step_go, resume;
  logic [3:0]       aluop;
  logic             Rwe, FLGwe, MEMwe, mem_req, ir_we, pc_inc, pc_load, illegal, bus_err, halt;
  logic [2:0]       dbg_state;
  logic [CNT_W-1:0] retired;

  controller_mc #(
    .IW      (IW),
    .CNT_W   (CNT_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .I         (I),
    .SZCy      (SZCy),
    .mem_ready (mem_ready),
    .step_mode (step_mode),
    .step_go   (step_go),
    .resume    (resume),
    .aluop     (aluop),
    .Rwe       (Rwe),
    .FLGwe     (FLGwe),
    .MEMwe     (MEMwe),
    .mem_req   (mem_req),
    .ir_we     (ir_we),
    .pc_inc    (pc_inc),
    .pc_load   (pc_load),
    .illegal   (illegal),
    .bus_err   (bus_err),
    .halt      (halt),
    .dbg_state (dbg_state),
    .retired   (retired)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    string            tag;
    logic [16:0]      outs;
    logic [CNT_W-1:0] ret;
  } exp_t;

  exp_t sb[$];

  int n_checks = 0;
  int n_fail   = 0;

  // Values applied on the next driven cycle.
  logic             rst_v, smode_v, sgo_v, res_v;
  logic [2:0]       flags_v;
  logic [CNT_W-1:0] exp_ret;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clock) begin : monitor
    exp_t e;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check_eq({e.tag, "/outs"},
               {15'd0, dbg_state, aluop, Rwe, FLGwe, MEMwe, mem_req, ir_we, pc_inc, pc_load,
                illegal, bus_err, halt},
               {15'd0, e.outs});
      check_eq({e.tag, "/retired"}, {{(32-CNT_W){1'b0}}, retired}, {{(32-CNT_W){1'b0}}, e.ret});
    end
  end

  task automatic cyc(input string tag, input logic [7:0] ins, input logic mr,
                     input logic [2:0] st, input logic [3:0] alu, input logic [9:0] strb);
    exp_t e;
    @(posedge clock);
    #1;
    reset     = rst_v;
    I         = ins;
    mem_ready = mr;
    SZCy      = flags_v;
    step_mode = smode_v;
    step_go   = sgo_v;
    resume    = res_v;
    e.tag  = tag;
    e.outs = {st, alu, strb};
    e.ret  = exp_ret;
    sb.push_back(e);
  endtask

  task automatic fetch(input string tag, input logic [7:0] ins);
    cyc({tag, "_f0"}, ins, 1'b1, SF0, 4'h0, MREQ);
    cyc({tag, "_f1"}, ins, 1'b1, SF1, 4'h0, MREQ | IRWE | PCINC);
  endtask

  initial begin
    reset = 1'b0; I = '0; SZCy = '0; mem_ready = 1'b0;
    step_mode = 1'b0; step_go = 1'b0; resume = 1'b0;
    rst_v = 1'b0; smode_v = 1'b0; sgo_v = 1'b0; res_v = 1'b0; flags_v = 3'b000;
    exp_ret = '0;

    cyc("reset", 8'h00, 1'b1, SF0, 4'h0, MREQ);
    rst_v = 1'b1;
    cyc("release", 8'h00, 1'b1, SF0, 4'h0, MREQ);

    // NOP then ALU 0x3
    cyc("nop_f1", 8'h00, 1'b1, SF1, 4'h0, MREQ | IRWE | PCINC);
    cyc("nop_x0", 8'h00, 1'b1, SX0, 4'h0, NONE);
    exp_ret++;
    fetch("alu", 8'h30);
    cyc("alu_x0", 8'h30, 1'b1, SX0, 4'h3, RWE | FLGWE);
    exp_ret++;

    // LD with three wait cycles; completes exactly when the timeout would fire
    fetch("ld", 8'h80);
    for (int k = 0; k < 3; k++) cyc("ld_wait", 8'h80, 1'b0, SX0, 4'h0, MREQ);
    cyc("ld_done", 8'h80, 1'b1, SX0, 4'h0, MREQ | RWE);
    exp_ret++;

    // ST with one wait; MEMwe held through the wait
    fetch("st", 8'h90);
    cyc("st_wait", 8'h90, 1'b0, SX0, 4'h0, MREQ | MEMWE);
    cyc("st_done", 8'h90, 1'b1, SX0, 4'h0, MREQ | MEMWE);
    exp_ret++;

    // Jumps, the first with a stalled fetch
    flags_v = 3'b010;
    cyc("jz_f0", 8'hA2, 1'b1, SF0, 4'h0, MREQ);
    cyc("jz_f1w", 8'hA2, 1'b0, SF1, 4'h0, MREQ);
    cyc("jz_f1", 8'hA2, 1'b1, SF1, 4'h0, MREQ | IRWE | PCINC);
    cyc("jz_x0", 8'hA2, 1'b1, SX0, 4'h0, PCLD);
    exp_ret++;
    fetch("jnz", 8'hA6);
    cyc("jnz_x0", 8'hA6, 1'b1, SX0, 4'h0, NONE);
    exp_ret++;
    flags_v = 3'b001;
    fetch("jc", 8'hA3);
    cyc("jc_x0", 8'hA3, 1'b1, SX0, 4'h0, PCLD);
    exp_ret++;
    flags_v = 3'b000;
    fetch("jns", 8'hA5);
    cyc("jns_x0", 8'hA5, 1'b1, SX0, 4'h0, PCLD);
    exp_ret++;

    // Illegal opcode; retired has wrapped to 0 here
    fetch("ill", 8'hC0);
    cyc("ill_x0", 8'hC0, 1'b1, SX0, 4'h0, ILL);
    exp_ret++;

    // Single-step
    smode_v = 1'b1;
    fetch("s1", 8'h00);
    cyc("s1_x0", 8'h00, 1'b1, SX0, 4'h0, NONE);
    exp_ret++;
    cyc("s1_pause", 8'h00, 1'b1, SPAUSE, 4'h0, NONE);
    cyc("s1_pause", 8'h00, 1'b1, SPAUSE, 4'h0, NONE);
    sgo_v = 1'b1;
    cyc("s1_go", 8'h00, 1'b1, SPAUSE, 4'h0, NONE);
    fetch("s2", 8'h10);
    cyc("s2_x0", 8'h10, 1'b1, SX0, 4'h1, RWE | FLGWE);
    exp_ret++;
    for (int k = 0; k < 3; k++) cyc("s2_held", 8'h10, 1'b1, SPAUSE, 4'h0, NONE);
    sgo_v = 1'b0;
    cyc("s2_low", 8'h10, 1'b1, SPAUSE, 4'h0, NONE);
    sgo_v = 1'b1;
    cyc("s2_go", 8'h10, 1'b1, SPAUSE, 4'h0, NONE);
    fetch("s3", 8'h00);
    cyc("s3_x0", 8'h00, 1'b1, SX0, 4'h0, NONE);
    exp_ret++;
    cyc("s3_pause", 8'h00, 1'b1, SPAUSE, 4'h0, NONE);
    smode_v = 1'b0;
    cyc("s3_modeoff", 8'h00, 1'b1, SPAUSE, 4'h0, NONE);
    sgo_v = 1'b0;

    // HLT, resume asserted in the fifth halt cycle
    fetch("hlt", 8'hF0);
    cyc("hlt_x0", 8'hF0, 1'b1, SX0, 4'h0, NONE);
    exp_ret++;
    for (int k = 0; k < 4; k++) cyc("hlt_wait", 8'hF0, 1'b1, SHLT, 4'h0, HALT);
    res_v = 1'b1;
    cyc("hlt_resume", 8'hF0, 1'b1, SHLT, 4'h0, HALT);
    res_v = 1'b0;

    // Fetch timeout after four stalled F1 cycles; no retire
    cyc("to_f0", 8'h00, 1'b0, SF0, 4'h0, MREQ);
    for (int k = 0; k < 4; k++) cyc("to_f1", 8'h00, 1'b0, SF1, 4'h0, MREQ);
    cyc("to_hlt", 8'h00, 1'b0, SHLT, 4'h0, HALT | BERR);
    res_v = 1'b1;
    cyc("to_resume", 8'h00, 1'b0, SHLT, 4'h0, HALT | BERR);
    res_v = 1'b0;
    cyc("to_sticky_f0", 8'h00, 1'b0, SF0, 4'h0, MREQ | BERR);
    cyc("to_sticky_f1", 8'h00, 1'b0, SF1, 4'h0, MREQ | BERR);

    // Asynchronous reset mid-wait clears everything at once
    rst_v   = 1'b0;
    exp_ret = '0;
    cyc("mid_reset", 8'h00, 1'b0, SF0, 4'h0, MREQ);
    rst_v = 1'b1;
    cyc("rel2", 8'h00, 1'b1, SF0, 4'h0, MREQ);
    cyc("post_f1", 8'h00, 1'b1, SF1, 4'h0, MREQ | IRWE | PCINC);
    cyc("post_x0", 8'h00, 1'b1, SX0, 4'h0, NONE);
    exp_ret++;
    cyc("post_f0", 8'h00, 1'b1, SF0, 4'h0, MREQ);

    @(posedge clock);
    #1;
    check_eq("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
